// File: rtl/query_mc_slave_pkg.sv
`default_nettype none
// ============================================================================
// query_mc_slave_pkg : register map, status bits and FSM encodings shared by
//                      the query control slave and its channel slots.
// Revision: 1.0
// ============================================================================
package query_mc_slave_pkg;

    localparam int QREG_FIELD_BITS = 3;

    localparam logic [QREG_FIELD_BITS-1:0] QREG_VADDR  = 3'd0;
    localparam logic [QREG_FIELD_BITS-1:0] QREG_LEN    = 3'd1;
    localparam logic [QREG_FIELD_BITS-1:0] QREG_PID    = 3'd2;
    localparam logic [QREG_FIELD_BITS-1:0] QREG_CTRL   = 3'd3;
    localparam logic [QREG_FIELD_BITS-1:0] QREG_STATUS = 3'd4;
    localparam logic [QREG_FIELD_BITS-1:0] QREG_DONE   = 3'd5;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;

    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_OVERRUN_BIT = 1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ACK  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/query_mc_slave_ch_slot.sv
`default_nettype none
// ============================================================================
// query_ch_slot : one query channel - descriptor registers, launch snapshot,
//                 pending/overrun tracking and completion counter.
// Revision: 1.0
// ============================================================================
module query_ch_slot
    import query_mc_slave_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int VADDR_BITS = 32,
    parameter int LEN_BITS   = 32,
    parameter int PID_BITS   = 6,
    parameter int CNT_BITS   = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       wr_en,
    input  logic [QREG_FIELD_BITS-1:0] wr_reg,
    input  logic [DATA_BITS-1:0]       wr_data,
    input  logic [DATA_BITS/8-1:0]     wr_strb,
    input  logic [QREG_FIELD_BITS-1:0] rd_reg,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [VADDR_BITS-1:0]      q_vaddr,
    output logic [LEN_BITS-1:0]        q_len,
    output logic [PID_BITS-1:0]        q_pid,
    input  logic                       q_done
);

    logic [DATA_BITS-1:0]  vaddr_q, vaddr_d;
    logic [DATA_BITS-1:0]  len_q, len_d;
    logic [DATA_BITS-1:0]  pid_q, pid_d;
    logic [VADDR_BITS-1:0] snap_vaddr_q, snap_vaddr_d;
    logic [LEN_BITS-1:0]   snap_len_q, snap_len_d;
    logic [PID_BITS-1:0]   snap_pid_q, snap_pid_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic start, clr_ovr, handshake, accept, cnt_clr;

    always_comb begin
        start     = wr_en && (wr_reg == QREG_CTRL) && wr_data[CTRL_START_BIT];
        clr_ovr   = wr_en && (wr_reg == QREG_CTRL) && wr_data[CTRL_CLR_OVR_BIT];
        cnt_clr   = wr_en && (wr_reg == QREG_DONE);
        handshake = pending_q && q_ready;
        // A handshake in the same cycle frees the slot for the new start
        accept    = start && (!pending_q || handshake);

        vaddr_d = vaddr_q;
        len_d   = len_q;
        pid_d   = pid_q;
        for (int b = 0; b < DATA_BITS/8; b++) begin
            if (wr_en && wr_strb[b]) begin
                if (wr_reg == QREG_VADDR) vaddr_d[b*8 +: 8] = wr_data[b*8 +: 8];
                if (wr_reg == QREG_LEN)   len_d[b*8 +: 8]   = wr_data[b*8 +: 8];
                if (wr_reg == QREG_PID)   pid_d[b*8 +: 8]   = wr_data[b*8 +: 8];
            end
        end

        snap_vaddr_d = snap_vaddr_q;
        snap_len_d   = snap_len_q;
        snap_pid_d   = snap_pid_q;
        if (accept) begin
            snap_vaddr_d = vaddr_q[VADDR_BITS-1:0];
            snap_len_d   = len_q[LEN_BITS-1:0];
            snap_pid_d   = pid_q[PID_BITS-1:0];
        end

        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (handshake) begin
            pending_d = 1'b0;
        end

        // Clear first so that clear+start on a busy channel re-flags overrun
        overrun_d = overrun_q;
        if (clr_ovr) overrun_d = 1'b0;
        if (start && !accept) overrun_d = 1'b1;

        cnt_d = cnt_q + CNT_BITS'(q_done);
        if (cnt_clr) cnt_d = CNT_BITS'(q_done);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vaddr_q      <= '0;
            len_q        <= '0;
            pid_q        <= '0;
            snap_vaddr_q <= '0;
            snap_len_q   <= '0;
            snap_pid_q   <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            vaddr_q      <= vaddr_d;
            len_q        <= len_d;
            pid_q        <= pid_d;
            snap_vaddr_q <= snap_vaddr_d;
            snap_len_q   <= snap_len_d;
            snap_pid_q   <= snap_pid_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_reg)
            QREG_VADDR:  rd_data = vaddr_q;
            QREG_LEN:    rd_data = len_q;
            QREG_PID:    rd_data = pid_q;
            QREG_STATUS: begin
                rd_data[STAT_PENDING_BIT] = pending_q;
                rd_data[STAT_OVERRUN_BIT] = overrun_q;
            end
            QREG_DONE:   rd_data = DATA_BITS'(cnt_q);
            default:     rd_data = '0;
        endcase
    end

    assign q_valid = pending_q;
    assign q_vaddr = snap_vaddr_q;
    assign q_len   = snap_len_q;
    assign q_pid   = snap_pid_q;

endmodule
`default_nettype wire

// File: rtl/query_mc_slave.sv
`default_nettype none
// ============================================================================
// query_mc_slave : AXI4-Lite control slave launching per-channel query
//                  descriptors and reporting their status/completions.
// Revision: 1.0
// ============================================================================
module query_mc_slave
    import query_mc_slave_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int AXIL_DATA_BITS = 32,
    parameter int AXIL_ADDR_BITS = 16,
    parameter int VADDR_BITS     = 32,
    parameter int LEN_BITS       = 32,
    parameter int PID_BITS       = 6,
    parameter int CNT_BITS       = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_awaddr,
    input  logic                          axi_ctrl_awvalid,
    output logic                          axi_ctrl_awready,
    input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
    input  logic                          axi_ctrl_wvalid,
    output logic                          axi_ctrl_wready,
    output logic [1:0]                    axi_ctrl_bresp,
    output logic                          axi_ctrl_bvalid,
    input  logic                          axi_ctrl_bready,
    input  logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_araddr,
    input  logic                          axi_ctrl_arvalid,
    output logic                          axi_ctrl_arready,
    output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
    output logic [1:0]                    axi_ctrl_rresp,
    output logic                          axi_ctrl_rvalid,
    input  logic                          axi_ctrl_rready,
    output logic [N_CH-1:0]               q_valid,
    input  logic [N_CH-1:0]               q_ready,
    output logic [N_CH*VADDR_BITS-1:0]    q_vaddr,
    output logic [N_CH*LEN_BITS-1:0]      q_len,
    output logic [N_CH*PID_BITS-1:0]      q_pid,
    input  logic [N_CH-1:0]               q_done
);

    localparam int ADDR_LSB    = $clog2(AXIL_DATA_BITS/8);
    localparam int CH_LSB      = ADDR_LSB + QREG_FIELD_BITS;
    localparam int CH_IDX_BITS = AXIL_ADDR_BITS - CH_LSB;
    localparam logic [CH_IDX_BITS-1:0] N_CH_IDX = CH_IDX_BITS'(N_CH);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXIL_DATA_BITS-1:0] rdata_q, rdata_d;

    // The full index above the register field is decoded, so addresses of
    // channels beyond N_CH error out instead of aliasing onto a real slot
    logic [QREG_FIELD_BITS-1:0] aw_reg, ar_reg;
    logic [CH_IDX_BITS-1:0]     aw_ch, ar_ch;
    logic                       aw_ok, ar_ok, wr_fire;
    logic [AXIL_DATA_BITS-1:0]  slot_rdata [N_CH];
    logic [AXIL_DATA_BITS-1:0]  rd_mux;

    assign aw_reg  = axi_ctrl_awaddr[CH_LSB-1:ADDR_LSB];
    assign ar_reg  = axi_ctrl_araddr[CH_LSB-1:ADDR_LSB];
    assign aw_ch   = axi_ctrl_awaddr[AXIL_ADDR_BITS-1:CH_LSB];
    assign ar_ch   = axi_ctrl_araddr[AXIL_ADDR_BITS-1:CH_LSB];
    assign aw_ok   = (aw_ch < N_CH_IDX);
    assign ar_ok   = (ar_ch < N_CH_IDX);
    assign wr_fire = (wr_state_q == WR_ACK);

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: if (axi_ctrl_awvalid && axi_ctrl_wvalid) wr_state_d = WR_ACK;
            WR_ACK: begin
                wr_state_d = WR_RESP;
                bresp_d    = aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            WR_RESP: if (axi_ctrl_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ar_ch == CH_IDX_BITS'(i)) rd_mux = slot_rdata[i];
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: if (axi_ctrl_arvalid) rd_state_d = RD_ACK;
            RD_ACK: begin
                rd_state_d = RD_RESP;
                rdata_d    = rd_mux;
                rresp_d    = ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            RD_RESP: if (axi_ctrl_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign axi_ctrl_awready = (wr_state_q == WR_ACK);
    assign axi_ctrl_wready  = (wr_state_q == WR_ACK);
    assign axi_ctrl_bvalid  = (wr_state_q == WR_RESP);
    assign axi_ctrl_bresp   = bresp_q;
    assign axi_ctrl_arready = (rd_state_q == RD_ACK);
    assign axi_ctrl_rvalid  = (rd_state_q == RD_RESP);
    assign axi_ctrl_rresp   = rresp_q;
    assign axi_ctrl_rdata   = rdata_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        query_ch_slot #(
            .DATA_BITS  (AXIL_DATA_BITS),
            .VADDR_BITS (VADDR_BITS),
            .LEN_BITS   (LEN_BITS),
            .PID_BITS   (PID_BITS),
            .CNT_BITS   (CNT_BITS)
        ) u_slot (
            .aclk    (aclk),
            .aresetn (aresetn),
            .wr_en   (wr_fire && (aw_ch == CH_IDX_BITS'(gi))),
            .wr_reg  (aw_reg),
            .wr_data (axi_ctrl_wdata),
            .wr_strb (axi_ctrl_wstrb),
            .rd_reg  (ar_reg),
            .rd_data (slot_rdata[gi]),
            .q_valid (q_valid[gi]),
            .q_ready (q_ready[gi]),
            .q_vaddr (q_vaddr[gi*VADDR_BITS +: VADDR_BITS]),
            .q_len   (q_len[gi*LEN_BITS +: LEN_BITS]),
            .q_pid   (q_pid[gi*PID_BITS +: PID_BITS]),
            .q_done  (q_done[gi])
        );
    end

    if (ADDR_LSB > 0) begin : g_unused_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^{axi_ctrl_awaddr[ADDR_LSB-1:0], axi_ctrl_araddr[ADDR_LSB-1:0]};
    end

endmodule
`default_nettype wire

// File: tb/tb_query_mc_slave.sv
`default_nettype none
// Directed bench for query_mc_slave: a 4-channel 32-bit counter build plus a
// 1-channel 4-bit counter build sharing the same AXI stimulus.
module tb_query_mc_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  q_valid;
    logic [3:0]  q_ready = '0, q_done = '0;
    logic [127:0] q_vaddr, q_len;
    logic [23:0]  q_pid;

    logic        s_unused_awready, s_unused_wready, s_unused_bvalid, s_unused_arready, s_unused_rvalid;
    logic [1:0]  s_unused_bresp, s_unused_rresp;
    logic [31:0] s_rdata;
    logic [0:0]  s_unused_q_valid;
    logic [0:0]  s_q_ready = '0, s_q_done = '0;
    logic [31:0] s_unused_q_vaddr, s_unused_q_len;
    logic [5:0]  s_unused_q_pid;

    int          vec = 0;
    int          errs = 0;
    logic [3:0]  qv_t1;
    logic [31:0] rd_s;
    logic [31:0] d;
    logic [1:0]  r;

    always #5 aclk = ~aclk;

    query_mc_slave #(.N_CH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_ctrl_awaddr(awaddr), .axi_ctrl_awvalid(awvalid), .axi_ctrl_awready(awready),
        .axi_ctrl_wdata(wdata), .axi_ctrl_wstrb(wstrb), .axi_ctrl_wvalid(wvalid), .axi_ctrl_wready(wready),
        .axi_ctrl_bresp(bresp), .axi_ctrl_bvalid(bvalid), .axi_ctrl_bready(bready),
        .axi_ctrl_araddr(araddr), .axi_ctrl_arvalid(arvalid), .axi_ctrl_arready(arready),
        .axi_ctrl_rdata(rdata), .axi_ctrl_rresp(rresp), .axi_ctrl_rvalid(rvalid), .axi_ctrl_rready(rready),
        .q_valid(q_valid), .q_ready(q_ready), .q_vaddr(q_vaddr), .q_len(q_len), .q_pid(q_pid), .q_done(q_done)
    );

    query_mc_slave #(.N_CH(1), .CNT_BITS(4)) dut_s (
        .aclk(aclk), .aresetn(aresetn),
        .axi_ctrl_awaddr(awaddr), .axi_ctrl_awvalid(awvalid), .axi_ctrl_awready(s_unused_awready),
        .axi_ctrl_wdata(wdata), .axi_ctrl_wstrb(wstrb), .axi_ctrl_wvalid(wvalid), .axi_ctrl_wready(s_unused_wready),
        .axi_ctrl_bresp(s_unused_bresp), .axi_ctrl_bvalid(s_unused_bvalid), .axi_ctrl_bready(bready),
        .axi_ctrl_araddr(araddr), .axi_ctrl_arvalid(arvalid), .axi_ctrl_arready(s_unused_arready),
        .axi_ctrl_rdata(s_rdata), .axi_ctrl_rresp(s_unused_rresp), .axi_ctrl_rvalid(s_unused_rvalid),
        .axi_ctrl_rready(rready),
        .q_valid(s_unused_q_valid), .q_ready(s_q_ready), .q_vaddr(s_unused_q_vaddr), .q_len(s_unused_q_len),
        .q_pid(s_unused_q_pid), .q_done(s_q_done)
    );

    function automatic logic [15:0] addr_of(input int ch, input int rg);
        return 16'((ch << 5) | (rg << 2));
    endfunction

    // Pulse masks are applied to q_ready/q_done exactly during the write's
    // handshake cycle so coincident-event corner cases can be hit.
    task automatic axi_write(input int ch, input int rg, input logic [31:0] data, input logic [3:0] strb,
                             input logic [3:0] rdy_pulse, input logic [3:0] done_pulse,
                             output logic [1:0] resp);
        int n;
        awaddr = addr_of(ch, rg); wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge aclk); #1; n++; end while (!awready && n < 20);
        if (!awready) begin vec++; errs++; $display("FAIL wr_timeout: awready=%0b required 1", awready); end
        q_ready = q_ready | rdy_pulse;
        q_done  = q_done | done_pulse;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        q_ready = q_ready & ~rdy_pulse;
        q_done  = q_done & ~done_pulse;
        qv_t1 = q_valid;
        resp  = bvalid ? bresp : 2'bxx;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input int ch, input int rg, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr_of(ch, rg); arvalid = 1'b1;
        n = 0;
        do begin @(posedge aclk); #1; n++; end while (!arready && n < 20);
        if (!arready) begin vec++; errs++; $display("FAIL rd_timeout: arready=%0b required 1", arready); end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        data = rvalid ? rdata : 32'hxxxx_xxxx;
        resp = rresp;
        rd_s = s_rdata;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        vec++; if ({q_valid, awready, wready, arready, bvalid, rvalid} !== 9'b0) begin
            errs++; $display("FAIL reset_ctl: got %b required 0", {q_valid, awready, wready, arready, bvalid, rvalid}); end
        vec++; if ({rdata, bresp, rresp} !== 36'h0) begin
            errs++; $display("FAIL reset_data: got %h required 0", {rdata, bresp, rresp}); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        for (int ch = 0; ch < 4; ch++) begin
            axi_read(ch, 4, d, r);
            vec++; if ({d, r} !== 34'h0) begin errs++; $display("FAIL reset_status ch%0d: got %h/%b required 0/00", ch, d, r); end
            axi_read(ch, 5, d, r);
            vec++; if ({d, r} !== 34'h0) begin errs++; $display("FAIL reset_done ch%0d: got %h/%b required 0/00", ch, d, r); end
            axi_read(ch, 0, d, r);
            vec++; if ({d, r} !== 34'h0) begin errs++; $display("FAIL reset_vaddr ch%0d: got %h/%b required 0/00", ch, d, r); end
        end
    endtask

    task automatic test_launch();
        axi_write(2, 0, 32'h1000_0040, 4'hF, 4'h0, 4'h0, r);
        vec++; if (r !== 2'b00) begin errs++; $display("FAIL launch_bresp: got %b required 00", r); end
        axi_write(2, 1, 32'h0000_0200, 4'hF, 4'h0, 4'h0, r);
        axi_write(2, 2, 32'h0000_0005, 4'hF, 4'h0, 4'h0, r);
        vec++; if (q_valid[2] !== 1'b0) begin errs++; $display("FAIL launch_idle: got %b required 0", q_valid[2]); end
        axi_write(2, 3, 32'h1, 4'hF, 4'h0, 4'h0, r);
        vec++; if (qv_t1[2] !== 1'b1) begin errs++; $display("FAIL launch_valid_t1: got %b required 1", qv_t1[2]); end
        vec++; if ({q_vaddr[64 +: 32], q_len[64 +: 32], q_pid[12 +: 6]} !== {32'h1000_0040, 32'h200, 6'd5}) begin
            errs++; $display("FAIL launch_snap: got %h %h %h required 10000040 200 5", q_vaddr[64 +: 32], q_len[64 +: 32], q_pid[12 +: 6]); end
        axi_write(2, 0, 32'h0000_DEAD, 4'hF, 4'h0, 4'h0, r);
        axi_write(2, 0, 32'hFFFF_FFFF, 4'b0010, 4'h0, 4'h0, r);
        vec++; if (q_vaddr[64 +: 32] !== 32'h1000_0040) begin
            errs++; $display("FAIL launch_snap_stable: got %h required 10000040", q_vaddr[64 +: 32]); end
        axi_read(2, 0, d, r);
        vec++; if (d !== 32'h0000_FFAD) begin errs++; $display("FAIL launch_wstrb: got %h required 0000ffad", d); end
        axi_read(2, 4, d, r);
        vec++; if (d !== 32'h1) begin errs++; $display("FAIL launch_status: got %h required 1", d); end
        q_ready[2] = 1'b1;
        @(posedge aclk); #1;
        q_ready[2] = 1'b0;
        vec++; if (q_valid[2] !== 1'b0) begin errs++; $display("FAIL launch_drain: got %b required 0", q_valid[2]); end
    endtask

    task automatic test_overrun();
        axi_write(0, 0, 32'h111, 4'hF, 4'h0, 4'h0, r);
        axi_write(0, 1, 32'h22, 4'hF, 4'h0, 4'h0, r);
        axi_write(0, 2, 32'h3, 4'hF, 4'h0, 4'h0, r);
        axi_write(0, 3, 32'h1, 4'hF, 4'h0, 4'h0, r);
        axi_write(0, 0, 32'h999, 4'hF, 4'h0, 4'h0, r);
        axi_write(0, 3, 32'h1, 4'hF, 4'h0, 4'h0, r);
        axi_read(0, 4, d, r);
        vec++; if (d !== 32'h3) begin errs++; $display("FAIL ovr_status: got %h required 3", d); end
        vec++; if (q_vaddr[0 +: 32] !== 32'h111) begin errs++; $display("FAIL ovr_snap: got %h required 111", q_vaddr[0 +: 32]); end
        axi_write(0, 3, 32'h2, 4'hF, 4'h0, 4'h0, r);
        axi_read(0, 4, d, r);
        vec++; if (d !== 32'h1) begin errs++; $display("FAIL ovr_clear: got %h required 1", d); end
        axi_write(0, 3, 32'h3, 4'hF, 4'h0, 4'h0, r);
        axi_read(0, 4, d, r);
        vec++; if (d !== 32'h3) begin errs++; $display("FAIL ovr_clr_then_start: got %h required 3", d); end
        q_ready[0] = 1'b1;
        @(posedge aclk); #1;
        q_ready[0] = 1'b0;
        axi_write(0, 3, 32'h2, 4'hF, 4'h0, 4'h0, r);
        axi_read(0, 4, d, r);
        vec++; if (d !== 32'h0) begin errs++; $display("FAIL ovr_idle: got %h required 0", d); end
    endtask

    task automatic test_back_to_back();
        axi_write(1, 0, 32'hA0, 4'hF, 4'h0, 4'h0, r);
        axi_write(1, 1, 32'h10, 4'hF, 4'h0, 4'h0, r);
        axi_write(1, 2, 32'h1, 4'hF, 4'h0, 4'h0, r);
        axi_write(1, 3, 32'h1, 4'hF, 4'h0, 4'h0, r);
        axi_write(1, 0, 32'hB0, 4'hF, 4'h0, 4'h0, r);
        axi_write(1, 3, 32'h1, 4'hF, 4'b0010, 4'h0, r);
        vec++; if (qv_t1[1] !== 1'b1) begin errs++; $display("FAIL b2b_valid: got %b required 1", qv_t1[1]); end
        vec++; if (q_vaddr[32 +: 32] !== 32'hB0) begin errs++; $display("FAIL b2b_snap: got %h required b0", q_vaddr[32 +: 32]); end
        axi_read(1, 4, d, r);
        vec++; if (d !== 32'h1) begin errs++; $display("FAIL b2b_status: got %h required 1", d); end
        q_ready[1] = 1'b1;
        @(posedge aclk); #1;
        q_ready[1] = 1'b0;
        vec++; if (q_valid[1] !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b required 0", q_valid[1]); end
    endtask

    task automatic test_done();
        for (int i = 0; i < 5; i++) begin
            q_done[3] = 1'b1; @(posedge aclk); #1; q_done[3] = 1'b0;
            @(posedge aclk); #1;
        end
        axi_read(3, 5, d, r);
        vec++; if (d !== 32'd5) begin errs++; $display("FAIL done_count: got %0d required 5", d); end
        axi_write(3, 5, 32'h0, 4'hF, 4'h0, 4'b1000, r);
        axi_read(3, 5, d, r);
        vec++; if (d !== 32'd1) begin errs++; $display("FAIL done_clr_coincident: got %0d required 1", d); end
        for (int i = 0; i < 15; i++) begin
            s_q_done[0] = 1'b1; @(posedge aclk); #1; s_q_done[0] = 1'b0;
        end
        axi_read(0, 5, d, r);
        vec++; if (rd_s !== 32'd15) begin errs++; $display("FAIL done_small_max: got %0d required 15", rd_s); end
        vec++; if (d !== 32'd0) begin errs++; $display("FAIL done_isolation: got %0d required 0", d); end
        s_q_done[0] = 1'b1; @(posedge aclk); #1; s_q_done[0] = 1'b0;
        axi_read(0, 5, d, r);
        vec++; if (rd_s !== 32'd0) begin errs++; $display("FAIL done_wrap: got %0d required 0", rd_s); end
    endtask

    task automatic test_slverr();
        axi_write(5, 0, 32'h1234, 4'hF, 4'h0, 4'h0, r);
        vec++; if (r !== 2'b10) begin errs++; $display("FAIL slverr_bresp: got %b required 10", r); end
        axi_read(1, 0, d, r);
        vec++; if (d !== 32'hB0) begin errs++; $display("FAIL slverr_no_alias: got %h required b0", d); end
        axi_read(5, 0, d, r);
        vec++; if ({d, r} !== {32'h0, 2'b10}) begin errs++; $display("FAIL slverr_read: got %h/%b required 0/10", d, r); end
    endtask

    task automatic test_reset_mid();
        int n;
        axi_write(2, 3, 32'h1, 4'hF, 4'h0, 4'h0, r);
        awaddr = addr_of(0, 0); wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge aclk); #1; n++; end while (!awready && n < 20);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        vec++; if ({bvalid, q_valid[2]} !== 2'b11) begin errs++; $display("FAIL rstmid_pre: got %b required 11", {bvalid, q_valid[2]}); end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        vec++; if ({bvalid, q_valid} !== 5'b0) begin errs++; $display("FAIL rstmid_drop: got %b required 0", {bvalid, q_valid}); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        axi_read(2, 4, d, r);
        vec++; if (d !== 32'h0) begin errs++; $display("FAIL rstmid_status: got %h required 0", d); end
        axi_read(0, 0, d, r);
        vec++; if (d !== 32'h0) begin errs++; $display("FAIL rstmid_vaddr: got %h required 0", d); end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_overrun();
        test_back_to_back();
        test_done();
        test_slverr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
